interp_ctrl: RTL and testbench

INTERP_CTRL -- requirements
Module: interp_ctrl

---
 rtl/interp_pkg.sv | 16 +
 rtl/interp_ctrl_if.sv | 31 +++
 rtl/interp_phase_acc.sv | 20 ++
 rtl/interp_ctrl.sv | 141 ++++++++++++++
 tb/tb_interp_ctrl.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/interp_pkg.sv
// Shared types and defaults for the Farrow interpolator controller.
// Holds the control state encoding, delay-line fill depth and default widths.
package interp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam int FILL_DEPTH      = 4;
    localparam int DEF_DATA_WIDTH  = 19;
    localparam int DEF_MU_WIDTH    = 16;
    localparam int DEF_STEP_WIDTH  = DEF_MU_WIDTH + 2;

endpackage

// File: rtl/interp_ctrl_if.sv
// Sample/output handshake bundle between a source, the interpolator
// controller and the Farrow datapath.
interface interp_ctrl_if
    import interp_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MU_WIDTH   = DEF_MU_WIDTH,
    parameter int STEP_WIDTH = MU_WIDTH + 2
);
    logic                  enable;
    logic [STEP_WIDTH-1:0] step;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  load_new_x;
    logic [DATA_WIDTH-1:0] x_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [MU_WIDTH-1:0]   mu;

    modport master (
        output enable, step, in_valid, in_data, out_ready,
        input  in_ready, load_new_x, x_in, out_valid, mu
    );

    modport slave (
        input  enable, step, in_valid, in_data, out_ready,
        output in_ready, load_new_x, x_in, out_valid, mu
    );

endinterface

// File: rtl/interp_phase_acc.sv
// Fractional-interval accumulator: adds step to mu on an output advance
// and splits the sum into the new mu and the number of samples to fetch.
module interp_phase_acc #(
    parameter int MU_WIDTH   = 16,
    parameter int STEP_WIDTH = MU_WIDTH + 2
) (
    input  logic [MU_WIDTH-1:0]            i_mu,
    input  logic [STEP_WIDTH-1:0]          i_step,
    input  logic                           i_adv,
    output logic [MU_WIDTH-1:0]            o_mu,
    output logic [STEP_WIDTH-MU_WIDTH:0]   o_pend
);

    logic [STEP_WIDTH:0] w_sum;

    assign w_sum  = {1'b0, i_step} + (STEP_WIDTH+1)'(i_mu);
    assign o_mu   = i_adv ? w_sum[MU_WIDTH-1:0] : i_mu;
    assign o_pend = i_adv ? w_sum[STEP_WIDTH:MU_WIDTH] : '0;

endmodule

// File: rtl/interp_ctrl.sv
// Farrow interpolator control: fills the delay line, then trades sample
// loads against output strobes. Optional counters via INTERP_CTRL_STATUS_EN.
module interp_ctrl
    import interp_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MU_WIDTH   = DEF_MU_WIDTH,
    parameter int STEP_WIDTH = MU_WIDTH + 2
) (
    input  logic          clk,
    input  logic          rst,
    interp_ctrl_if.slave  bus
`ifdef INTERP_CTRL_STATUS_EN
    ,
    output logic [15:0]   out_cnt,
    output logic [15:0]   stall_cnt
`endif
);

    localparam int PW = STEP_WIDTH - MU_WIDTH + 1;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [PW-1:0]         r_pend;
    logic [PW-1:0]         w_pend_nxt;
    logic [MU_WIDTH-1:0]   r_mu;
    logic [MU_WIDTH-1:0]   w_mu_nxt;
    logic                  w_in_ready;
    logic                  w_out_valid;
    logic                  w_adv;
    logic [MU_WIDTH-1:0]   w_acc_mu;
    logic [PW-1:0]         w_acc_pend;
    logic [DATA_WIDTH-1:0] w_x;

    assign w_adv = w_out_valid && bus.out_ready;

    interp_phase_acc #(
        .MU_WIDTH   (MU_WIDTH),
        .STEP_WIDTH (STEP_WIDTH)
    ) u_acc (
        .i_mu   (r_mu),
        .i_step (bus.step),
        .i_adv  (w_adv),
        .o_mu   (w_acc_mu),
        .o_pend (w_acc_pend)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_pend  <= '0;
            r_mu    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= w_pend_nxt;
            r_mu    <= w_mu_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pend_nxt  = r_pend;
        w_mu_nxt    = r_mu;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.enable) begin
                    w_state_nxt = FILL;
                    w_pend_nxt  = PW'(FILL_DEPTH);
                    w_mu_nxt    = '0;
                end
            end
            FILL: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_pend_nxt = r_pend - 1'b1;
                    if (r_pend == PW'(1))
                        w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (r_pend == '0) begin
                    w_out_valid = 1'b1;
                    if (bus.out_ready) begin
                        w_mu_nxt   = w_acc_mu;
                        w_pend_nxt = w_acc_pend;
                    end
                end else begin
                    w_in_ready = 1'b1;
                    if (bus.in_valid)
                        w_pend_nxt = r_pend - 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_pend_nxt  = '0;
                w_mu_nxt    = '0;
            end
        endcase
        // Dropping enable kills both handshakes in the same cycle
        if (!bus.enable) begin
            w_state_nxt = IDLE;
            w_pend_nxt  = '0;
            w_mu_nxt    = '0;
            w_in_ready  = 1'b0;
            w_out_valid = 1'b0;
        end
    end

    assign w_x            = bus.in_data;
    assign bus.x_in       = w_x;
    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = w_out_valid;
    assign bus.load_new_x = bus.in_valid && w_in_ready;
    assign bus.mu         = r_mu;

`ifdef INTERP_CTRL_STATUS_EN
    logic [15:0] r_out_cnt;
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_cnt   <= '0;
            r_stall_cnt <= '0;
        end else if (w_state_nxt == IDLE) begin
            r_out_cnt   <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_adv)
                r_out_cnt <= r_out_cnt + 16'd1;
            if (w_in_ready && !bus.in_valid && r_stall_cnt != 16'hFFFF)
                r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign out_cnt   = r_out_cnt;
    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_interp_ctrl.sv
// Directed bench for interp_ctrl: fill, up/downsample, backpressure,
// reset/enable abort and (with INTERP_CTRL_STATUS_EN) status counters.
module tb_interp_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   nvec = 0;
    int   nerr = 0;

    interp_ctrl_if bus ();

`ifdef INTERP_CTRL_STATUS_EN
    logic [15:0] out_cnt;
    logic [15:0] stall_cnt;
`endif

    interp_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef INTERP_CTRL_STATUS_EN
        ,
        .out_cnt   (out_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_load(input string tag);
        #1;
        chk({tag, "_load"}, 32'(bus.load_new_x), 32'd1);
        chk({tag, "_ovld"}, 32'(bus.out_valid), 32'd0);
        tick();
    endtask

    task automatic expect_out(input string tag, input logic [15:0] m);
        #1;
        chk({tag, "_ovld"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_irdy"}, 32'(bus.in_ready), 32'd0);
        chk({tag, "_mu"}, 32'(bus.mu), 32'(m));
        tick();
    endtask

    task automatic fill(input string tag);
        logic [18:0] d;
        bus.enable   = 1'b1;
        bus.in_valid = 1'b1;
        #1;
        chk({tag, "_idle_irdy"}, 32'(bus.in_ready), 32'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            d = 19'h5A5A0 + 19'(i);
            bus.in_data = d;
            #1;
            chk({tag, "_fill_x"}, 32'(bus.x_in), 32'(19'h5A5A0 + 19'(i)));
            expect_load({tag, "_fill"});
        end
    endtask

    task automatic abort();
        bus.enable = 1'b0;
        tick();
    endtask

    initial begin
        rst           = 1'b1;
        bus.enable    = 1'b0;
        bus.step      = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        #2;
        chk("rst_irdy", 32'(bus.in_ready), 32'd0);
        chk("rst_ovld", 32'(bus.out_valid), 32'd0);
        chk("rst_mu", 32'(bus.mu), 32'd0);
        tick();
        tick();
        rst = 1'b0;

        // unity step: 4 fill loads, then load/output alternating at mu=0
        bus.step = 18'h10000;
        fill("unity");
        expect_out("unity0", 16'h0000);
        for (int i = 0; i < 3; i++) begin
            expect_load("unity_ld");
            expect_out("unity", 16'h0000);
        end
        abort();

        // 2x upsample, then step=0 freezes mu with no loads
        bus.step = 18'h08000;
        fill("up");
        expect_out("up0", 16'h0000);
        expect_out("up1", 16'h8000);
        expect_load("up_ld");
        bus.step = 18'h3FFFF;
        #1;
        bus.step = 18'h08000;
        expect_out("up2", 16'h0000);
        bus.step = 18'h00000;
        expect_out("up3", 16'h8000);
        for (int i = 0; i < 3; i++)
            expect_out("zero", 16'h8000);
        abort();

        // 1.5x downsample with a 5-cycle output stall
        bus.step = 18'h18000;
        fill("dn");
        expect_out("dn0", 16'h0000);
        expect_load("dn_ld1");
        expect_out("dn1", 16'h8000);
        expect_load("dn_ld2a");
        expect_load("dn_ld2b");
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_ovld", 32'(bus.out_valid), 32'd1);
            chk("bp_irdy", 32'(bus.in_ready), 32'd0);
            chk("bp_load", 32'(bus.load_new_x), 32'd0);
            chk("bp_mu", 32'(bus.mu), 32'h0000);
            tick();
        end
        bus.out_ready = 1'b1;
        expect_out("bp_hs", 16'h0000);
        expect_load("bp_after");
        expect_out("dn2", 16'h8000);

        // pend=2 here: reset immediately idles the block
        expect_load("pre_rst");
        rst = 1'b1;
        #1;
        chk("arst_irdy", 32'(bus.in_ready), 32'd0);
        chk("arst_load", 32'(bus.load_new_x), 32'd0);
        chk("arst_ovld", 32'(bus.out_valid), 32'd0);
        chk("arst_mu", 32'(bus.mu), 32'd0);
        tick();
        rst = 1'b0;
        fill("rf");
        expect_out("rf0", 16'h0000);
        expect_load("rf_ld1");
        expect_out("rf1", 16'h8000);
        expect_load("rf_pend2");
        bus.enable = 1'b0;
        #1;
        chk("en_irdy", 32'(bus.in_ready), 32'd0);
        chk("en_load", 32'(bus.load_new_x), 32'd0);
        tick();
        #1;
        chk("en_idle_irdy", 32'(bus.in_ready), 32'd0);
        chk("en_idle_ovld", 32'(bus.out_valid), 32'd0);
        chk("en_idle_mu", 32'(bus.mu), 32'd0);
        fill("ref");
        expect_out("ref0", 16'h0000);

`ifdef INTERP_CTRL_STATUS_EN
        abort();
        #1;
        chk("st_clr", 32'(out_cnt), 32'd0);
        bus.step = 18'h10000;
        fill("st");
        expect_out("st0", 16'h0000);
        bus.in_valid = 1'b0;
        tick();
        tick();
        bus.in_valid = 1'b1;
        expect_load("st_ld1");
        expect_out("st1", 16'h0000);
        expect_load("st_ld2");
        bus.out_ready = 1'b0;
        #1;
        chk("st_cnt_pre", 32'(out_cnt), 32'd2);
        bus.out_ready = 1'b1;
        expect_out("st2", 16'h0000);
        bus.in_valid = 1'b1;
        bus.enable   = 1'b1;
        bus.out_ready = 1'b0;
        bus.step = 18'h10000;
        #1;
        chk("st_out", 32'(out_cnt), 32'd3);
        chk("st_stall", 32'(stall_cnt), 32'd2);
        bus.out_ready = 1'b1;
        abort();
        bus.step = 18'h00000;
        bus.out_ready = 1'b0;
        fill("wrap");
        bus.out_ready = 1'b1;
        repeat (65537) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        #1;
        chk("st_wrap", 32'(out_cnt), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
